crc_frame_checker: RTL

CRC_FRAME_CHECKER -- requirements
Module: crc_frame_checker

---
 rtl/crc_frame_checker.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/crc_frame_checker.sv
// crc_frame_checker
//
// Receives byte frames, runs CRC-16/CCITT-FALSE (poly 0x1021, MSB-first,
// no reflection, no final XOR) over every byte including the two trailing
// CRC bytes, and forwards the payload with the CRC bytes stripped.
// A frame is good when the CRC residue after its final byte is zero.
//
// Parameters
//   INIT     CRC preset loaded on the first byte of every frame
//   TIMEOUT  max consecutive idle cycles inside a frame (0 = no timeout)
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   d, dv, last  received byte, its valid strobe, end-of-frame qualifier
//   pay_d        payload byte (CRC bytes stripped)
//   pay_dv       pay_d valid
//   pay_last     final payload byte of a frame
//   done         one-cycle end-of-frame pulse
//   crc_ok       last frame's CRC residue was zero
//   len          payload byte count of the last frame (saturating)
//   err_short    last frame had fewer than 2 bytes
//   err_timeout  last frame was aborted by the idle timeout

module crc_frame_checker #(
  parameter logic [15:0] INIT    = 16'hffff,
  parameter int          TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  d,
  input  logic        dv,
  input  logic        last,
  output logic [7:0]  pay_d,
  output logic        pay_dv,
  output logic        pay_last,
  output logic        done,
  output logic        crc_ok,
  output logic [15:0] len,
  output logic        err_short,
  output logic        err_timeout
);

  // Idle counter only needs to reach TIMEOUT-1; keep at least one bit so
  // the design still elaborates when the timeout is disabled.
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, RX} state_t;

  state_t        state;
  state_t        state_next;
  logic [15:0]   crc;
  logic [15:0]   crc_base;
  logic [15:0]   crc_next;
  logic [7:0]    dl_old;
  logic [7:0]    dl_new;
  logic [1:0]    dl_cnt;
  logic [15:0]   pay_cnt;
  logic [15:0]   pay_cnt_inc;
  logic [IW-1:0] idle_cnt;
  logic          timeout_hit;

  // One byte of CRC-16/CCITT-FALSE, MSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // The first byte of a frame always starts from the preset, so a new frame
  // may follow the previous one with no gap.
  assign crc_base    = (state == IDLE) ? INIT : crc;
  assign crc_next    = crc_byte(crc_base, d);
  assign pay_cnt_inc = (pay_cnt == 16'hffff) ? pay_cnt : pay_cnt + 16'd1;

  // The timeout fires on the TIMEOUT-th consecutive idle cycle inside a frame.
  assign timeout_hit = (TIMEOUT != 0) && (state == RX) && !dv && (idle_cnt == IDLE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dv && !last) begin
          state_next = RX;
        end
      end
      RX: begin
        if ((dv && last) || timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: CRC register, 2-entry delay line holding the bytes that may
  // turn out to be the CRC, payload push-out, and end-of-frame results.
  // The delay line count is only meaningful in RX; in IDLE the next byte
  // always reloads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc         <= INIT;
      dl_old      <= 8'h00;
      dl_new      <= 8'h00;
      dl_cnt      <= 2'd0;
      pay_cnt     <= 16'd0;
      idle_cnt    <= '0;
      pay_d       <= 8'h00;
      pay_dv      <= 1'b0;
      pay_last    <= 1'b0;
      done        <= 1'b0;
      crc_ok      <= 1'b0;
      len         <= 16'd0;
      err_short   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      pay_dv   <= 1'b0;
      pay_last <= 1'b0;
      done     <= 1'b0;

      if ((state == RX) && !dv && !timeout_hit) begin
        idle_cnt <= idle_cnt + IW'(1);
      end else begin
        idle_cnt <= '0;
      end

      if (dv) begin
        crc <= crc_next;
        if (state == IDLE) begin
          dl_old  <= d;
          dl_cnt  <= 2'd1;
          pay_cnt <= 16'd0;
          if (last) begin
            done        <= 1'b1;
            crc_ok      <= 1'b0;
            len         <= 16'd0;
            err_short   <= 1'b1;
            err_timeout <= 1'b0;
            dl_cnt      <= 2'd0;
          end
        end else begin
          // A full delay line means its oldest byte is certainly payload.
          if (dl_cnt == 2'd2) begin
            pay_d    <= dl_old;
            pay_dv   <= 1'b1;
            pay_last <= last;
            dl_old   <= dl_new;
            dl_new   <= d;
            pay_cnt  <= pay_cnt_inc;
          end else begin
            dl_new <= d;
            dl_cnt <= 2'd2;
          end
          if (last) begin
            done        <= 1'b1;
            crc_ok      <= (crc_next == 16'h0000);
            len         <= (dl_cnt == 2'd2) ? pay_cnt_inc : pay_cnt;
            err_short   <= 1'b0;
            err_timeout <= 1'b0;
            dl_cnt      <= 2'd0;
          end
        end
      end else if (timeout_hit) begin
        done        <= 1'b1;
        crc_ok      <= 1'b0;
        len         <= 16'd0;
        err_short   <= 1'b0;
        err_timeout <= 1'b1;
        dl_cnt      <= 2'd0;
      end
    end
  end

endmodule
